// File: rtl/rvv_pkg.sv
// Shared types for the vector lane writeback path: SEW codes, op types,
// writeback FSM states and lane field widths.
package rvv_pkg;

  localparam int LANE_VD_W  = 64;
  localparam int LANE_IDX_W = 17;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } sew_e;

  typedef enum logic [2:0] {
    OP_VV = 3'b001,
    OP_VX = 3'b010,
    OP_VI = 3'b100
  } op_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } wb_state_e;

  // Low-order all-ones pattern covering one element of the given SEW code.
  function automatic logic [LANE_VD_W-1:0] sew_ones(input logic [2:0] vsew);
    case (vsew)
      3'd0:    sew_ones = 64'h0000_0000_0000_00FF;
      3'd1:    sew_ones = 64'h0000_0000_0000_FFFF;
      3'd2:    sew_ones = 64'h0000_0000_FFFF_FFFF;
      default: sew_ones = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/rvv_elem_insert.sv
// Combinational element insert: replaces element idx (width 8<<vsew) of a
// VLEN-bit register image with the low SEW bits of value when en is high.
module rvv_elem_insert
  import rvv_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic [VLEN-1:0]      vreg_in,
  input  logic [LANE_VD_W-1:0] value,
  input  logic [LANE_IDX_W-1:0] idx,
  input  logic [2:0]           vsew,
  input  logic                 en,
  output logic [VLEN-1:0]      vreg_out
);

  logic [VLEN-1:0] mask_ext;
  logic [VLEN-1:0] val_ext;
  logic [22:0]     shamt;

  // Bit offset of the element; callers only enable in-range indices.
  assign shamt = {3'b000, idx, 3'b000} << vsew;

  always_comb begin
    mask_ext        = '0;
    val_ext         = '0;
    mask_ext[63:0]  = sew_ones(vsew);
    val_ext[63:0]   = value;
    mask_ext        = mask_ext << shamt;
    val_ext         = val_ext << shamt;
  end

  assign vreg_out = en ? ((vreg_in & ~mask_ext) | (val_ext & mask_ext)) : vreg_in;

endmodule

// File: rtl/rvv_lane_writeback.sv
// Collects lane element beats into a staging copy of vd and issues one VRF write.
// Optional masking (vm/v0 ports) is compiled in with RVV_WB_MASK_EN.
//   state   | meaning
//   IDLE    | waiting for start
//   COLLECT | merging lane beats until alu_done
//   WRITE   | wb_valid held until wb_ready
module rvv_lane_writeback
  import rvv_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               start,
  input  logic [4:0]                         vd_index,
  input  logic [2:0]                         vsew,
  input  logic [16:0]                        vl,
  input  logic [VLEN-1:0]                    old_vd,
`ifdef RVV_WB_MASK_EN
  input  logic                               vm,
  input  logic [VLEN-1:0]                    v0,
`endif
  input  logic [(LANE_VD_W<<NB_LANES)-1:0]   lane_vd,
  input  logic [(LANE_IDX_W<<NB_LANES)-1:0]  lane_idx,
  input  logic [(1<<NB_LANES)-1:0]           lane_valid,
  input  logic                               alu_done,
  output logic                               wb_valid,
  output logic [4:0]                         wb_index,
  output logic [VLEN-1:0]                    wb_data,
  input  logic                               wb_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int LANES  = 1 << NB_LANES;
  localparam int VIDX_W = $clog2(VLEN);

  wb_state_e         state, state_nx;
  logic [4:0]        vd_q;
  logic [2:0]        vsew_q;
  logic [16:0]       vl_q;
  logic [VLEN-1:0]   vreg_q;
  logic              err_q;
  logic              done_q;
  logic [16:0]       epr;
  logic              beat_err;
  logic [VLEN-1:0]   chain [LANES+1];
`ifdef RVV_WB_MASK_EN
  logic              vm_q;
  logic [VLEN-1:0]   v0_q;
`endif

  assign epr      = 17'(VLEN >> ({1'b0, vsew_q} + 4'd3));
  assign chain[0] = vreg_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_IDX_W-1:0] idx;
    logic                  en;
    assign idx = lane_idx[LANE_IDX_W*g +: LANE_IDX_W];
`ifdef RVV_WB_MASK_EN
    assign en = lane_valid[g] && (idx < epr) && (idx < vl_q) && (vm_q || v0_q[idx[VIDX_W-1:0]]);
`else
    assign en = lane_valid[g] && (idx < epr) && (idx < vl_q);
`endif
    // Ascending chain: a higher lane overwrites a lower one on the same idx.
    rvv_elem_insert #(.VLEN(VLEN)) u_insert (
      .vreg_in  (chain[g]),
      .value    (lane_vd[LANE_VD_W*g +: LANE_VD_W]),
      .idx      (idx),
      .vsew     (vsew_q),
      .en       (en),
      .vreg_out (chain[g+1])
    );
  end

  always_comb begin
    beat_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_valid[i] && (lane_idx[LANE_IDX_W*i +: LANE_IDX_W] >= epr)) beat_err = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)    state_nx = COLLECT;
      COLLECT: if (alu_done) state_nx = WRITE;
      WRITE:   if (wb_ready) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      vd_q   <= '0;
      vsew_q <= '0;
      vl_q   <= '0;
      vreg_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef RVV_WB_MASK_EN
      vm_q   <= 1'b1;
      v0_q   <= '0;
`endif
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vd_q   <= vd_index;
            vsew_q <= vsew;
            vl_q   <= vl;
            vreg_q <= old_vd;
            err_q  <= 1'b0;
`ifdef RVV_WB_MASK_EN
            vm_q   <= vm;
            v0_q   <= v0;
`endif
          end
        end
        COLLECT: begin
          vreg_q <= chain[LANES];
          if (beat_err) err_q <= 1'b1;
        end
        WRITE: begin
          if (wb_ready) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wb_valid = (state == WRITE);
  assign wb_index = vd_q;
  assign wb_data  = vreg_q;
  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rvv_lane_writeback.sv
// Scoreboard bench for rvv_lane_writeback (VLEN=128, two lanes); mask cases
// are included when RVV_WB_MASK_EN is defined.
module tb_rvv_lane_writeback;

  localparam int VLEN     = 128;
  localparam int NB_LANES = 1;

  logic          clk = 1'b0;
  logic          resetn, start, alu_done, wb_ready;
  logic [4:0]    vd_index;
  logic [2:0]    vsew;
  logic [16:0]   vl;
  logic [127:0]  old_vd;
  logic [127:0]  lane_vd;
  logic [33:0]   lane_idx;
  logic [1:0]    lane_valid;
  logic          wb_valid, busy, done, err;
  logic [4:0]    wb_index;
  logic [127:0]  wb_data;
`ifdef RVV_WB_MASK_EN
  logic          vm;
  logic [127:0]  v0;
`endif

  always #5 clk = ~clk;

  rvv_lane_writeback #(.VLEN(VLEN), .NB_LANES(NB_LANES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .vd_index   (vd_index),
    .vsew       (vsew),
    .vl         (vl),
    .old_vd     (old_vd),
`ifdef RVV_WB_MASK_EN
    .vm         (vm),
    .v0         (v0),
`endif
    .lane_vd    (lane_vd),
    .lane_idx   (lane_idx),
    .lane_valid (lane_valid),
    .alu_done   (alu_done),
    .wb_valid   (wb_valid),
    .wb_index   (wb_index),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [127:0] data;
    logic [4:0]   index;
    logic         err;
  } exp_t;

  exp_t         sb_q[$];
  int           n_vec = 0;
  int           n_miscomp = 0;

  logic [127:0] mdl;
  logic [2:0]   m_sew;
  logic [16:0]  m_vl;
  logic [4:0]   m_vd;
  logic         m_err;
  logic         m_vm;
  logic [127:0] m_v0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miscomp++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference element merge, bit by bit.
  task automatic mdl_beat(input logic [16:0] idx, input logic [63:0] val);
    int sew;
    int epr;
    sew = 8 << m_sew;
    epr = 128 / sew;
    if (int'(idx) >= epr) m_err = 1'b1;
    else if (idx < m_vl && (m_vm || m_v0[idx[6:0]])) begin
      for (int b = 0; b < sew; b++) mdl[int'(idx)*sew + b] = val[b];
    end
  endtask

  task automatic start_op(input logic [4:0] vd, input logic [2:0] sew, input logic [16:0] len,
                          input logic [127:0] old, input logic mvm, input logic [127:0] mv0);
    start = 1'b1; vd_index = vd; vsew = sew; vl = len; old_vd = old;
`ifdef RVV_WB_MASK_EN
    vm = mvm; v0 = mv0;
    m_vm = mvm; m_v0 = mv0;
`else
    m_vm = 1'b1; m_v0 = mv0;
    if (mvm) m_v0 = '0;
`endif
    mdl = old; m_sew = sew; m_vl = len; m_vd = vd; m_err = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic va, input logic [16:0] ia, input logic [63:0] da,
                      input logic vb, input logic [16:0] ib, input logic [63:0] db,
                      input logic last);
    exp_t e;
    lane_valid = {vb, va}; lane_idx = {ib, ia}; lane_vd = {db, da}; alu_done = last;
    if (va) mdl_beat(ia, da);
    if (vb) mdl_beat(ib, db);
    if (last) begin
      e.data = mdl; e.index = m_vd; e.err = m_err;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    lane_valid = '0; alu_done = 1'b0;
  endtask

  task automatic finish_write(input int stall);
    check_val("wb_valid_lat", wb_valid, 1'b1);
    check_val("busy_write", busy, 1'b1);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_val("stall_valid", wb_valid, 1'b1);
      check_val("stall_done", done, 1'b0);
      if (sb_q.size() > 0) check_val("stall_data", wb_data, sb_q[0].data);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    check_val("done_pulse", done, 1'b1);
    check_val("valid_drop", wb_valid, 1'b0);
    check_val("busy_drop", busy, 1'b0);
    @(posedge clk); #1;
    check_val("done_once", done, 1'b0);
  endtask

  // Scoreboard: pop on each observed write handshake.
  always @(negedge clk) begin
    if (resetn && wb_valid && wb_ready) begin
      check_val("sb_pending", 128'(sb_q.size() > 0), 1'b1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("wb_data", wb_data, e.data);
        check_val("wb_index", wb_index, e.index);
        check_val("err", err, e.err);
      end
    end
  end

  initial begin
    resetn = 1'b0; start = 1'b0; vd_index = '0; vsew = '0; vl = '0; old_vd = '0;
    lane_vd = '0; lane_idx = '0; lane_valid = '0; alu_done = 1'b0; wb_ready = 1'b0;
`ifdef RVV_WB_MASK_EN
    vm = 1'b1; v0 = '0;
`endif
    m_vm = 1'b1; m_v0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_wb_valid", wb_valid, 1'b0);
    check_val("rst_wb_index", wb_index, 5'd0);
    check_val("rst_wb_data", wb_data, 128'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", err, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Bytes: lanes carry idx 2k and 2k+1 with value k.
    start_op(5'd7, 3'd0, 17'd16, 128'd0, 1'b1, '0);
    check_val("busy_collect", busy, 1'b1);
    for (int k = 0; k < 8; k++)
      beat(1'b1, 17'(2*k), 64'(k), 1'b1, 17'(2*k+1), 64'(k), k == 7);
    if (sb_q.size() > 0)
      check_val("pattern_ref", sb_q[0].data, 128'h0707060605050404_0303020201010000);
    finish_write(0);

    // 32-bit elements over all-ones base, with a 5-cycle stall.
    start_op(5'd12, 3'd2, 17'd2, {128{1'b1}}, 1'b1, '0);
    beat(1'b1, 17'd0, 64'h11111111, 1'b1, 17'd1, 64'h22222222, 1'b1);
    finish_write(5);

    // Out-of-range index sets err; in-range beat still lands.
    start_op(5'd3, 3'd2, 17'd4, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1, '0);
    beat(1'b1, 17'd4, 64'hDEADBEEF, 1'b0, 17'd0, 64'd0, 1'b0);
    check_val("err_sticky", err, 1'b1);
    beat(1'b1, 17'd3, 64'h12345678, 1'b0, 17'd0, 64'd0, 1'b1);
    finish_write(1);

    // Tail index beyond vl: dropped, err stays clear.
    start_op(5'd4, 3'd2, 17'd2, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 1'b1, '0);
    beat(1'b1, 17'd3, 64'h99999999, 1'b0, 17'd0, 64'd0, 1'b1);
    finish_write(0);

    // Same idx on both lanes: lane 1 wins; start during COLLECT ignored.
    start_op(5'd6, 3'd0, 17'd16, 128'd0, 1'b1, '0);
    start = 1'b1; vd_index = 5'd9;
    beat(1'b1, 17'd3, 64'hAA, 1'b1, 17'd3, 64'hBB, 1'b1);
    start = 1'b0;
    finish_write(0);

    // Beats in IDLE are ignored; vl=0 returns old_vd.
    lane_valid = 2'b11; lane_idx = {17'd1, 17'd0}; lane_vd = {64'hFF, 64'hEE};
    @(posedge clk); #1;
    lane_valid = '0;
    start_op(5'd31, 3'd0, 17'd0, 128'hFEEDFACE_CAFEF00D_0BADBEEF_12345678, 1'b1, '0);
    beat(1'b1, 17'd0, 64'h55, 1'b1, 17'd1, 64'h66, 1'b1);
    finish_write(2);

    // 64-bit elements: both lanes.
    start_op(5'd17, 3'd3, 17'd2, 128'd0, 1'b1, '0);
    beat(1'b1, 17'd1, 64'h0102030405060708, 1'b1, 17'd0, 64'h1112131415161718, 1'b1);
    finish_write(0);

`ifdef RVV_WB_MASK_EN
    // Masked: only elements with v0 bit set are written.
    start_op(5'd2, 3'd0, 17'd16, 128'd0, 1'b0, 128'h5);
    beat(1'b1, 17'd0, 64'h11, 1'b1, 17'd1, 64'h22, 1'b0);
    beat(1'b1, 17'd2, 64'h33, 1'b1, 17'd3, 64'h44, 1'b1);
    if (sb_q.size() > 0) check_val("mask_ref", sb_q[0].data, 128'h0000_0033_0011);
    finish_write(0);
`endif

    // Reset during WRITE abandons the write.
    start_op(5'd8, 3'd0, 17'd16, 128'd0, 1'b1, '0);
    beat(1'b1, 17'd0, 64'h77, 1'b0, 17'd0, 64'd0, 1'b1);
    check_val("pre_rst_valid", wb_valid, 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check_val("rst_write_valid", wb_valid, 1'b0);
    check_val("rst_write_busy", busy, 1'b0);
    check_val("rst_write_data", wb_data, 128'd0);
    sb_q.delete();
    resetn = 1'b1;
    @(posedge clk); #1;

    check_val("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
